instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pc_next.sv | 26 ++
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP constant, base opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StHold  = 2'd2,
        StFault = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or redirect target, plus target alignment check.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (flag misaligned targets instead of
// silently clearing the low two bits).
module pc_next (
    input  logic [31:0] pc,
    input  logic        pcsrc,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    assign pc_plus4 = pc + 32'd4;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign next_pc    = pcsrc ? pc_target : pc_plus4;
    assign misaligned = pcsrc & (pc_target[1:0] != 2'b00);
`else
    // Low bits are dropped on load, so a misaligned redirect can never occur.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^pc_target[1:0];
    assign next_pc         = pcsrc ? {pc_target[31:2], 2'b00} : pc_plus4;
    assign misaligned      = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: request, capture, hold until consumed.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned redirect enters a sticky
// FAULT state).
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic [31:0] pc_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;
    logic         misaligned;

    pc_next u_pc_next (
        .pc         (pc_q),
        .pcsrc      (pcsrc),
        .pc_target  (pc_target),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // Next-state logic; acks outside StReq and redirects outside a consume cycle are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = misaligned ? StFault : StReq;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NopInstr;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        imem_req    = (state_q == StReq);
        imem_addr   = pc_q;
        instr_valid = (state_q == StHold);
        instr       = instr_q;
        pc          = pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
        fault       = (state_q == StFault);
`else
        fault       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam logic [31:0] Nop   = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_CHECK_EN
    localparam bit MisalignCheck = 1'b1;
`else
    localparam bit MisalignCheck = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pc_target = '0;
    logic [31:0] instr, pc, pc_plus4;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RstPc)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .pc_target   (pc_target),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one fetch in flight, described as transaction phases.
    logic [31:0] m_pc = RstPc, m_instr = Nop;
    bit m_booting = 1'b1, m_fetching = 1'b0, m_have = 1'b0, m_fault = 1'b0;

    task automatic step(input logic rst, input logic ack, input logic [31:0] rdata,
                        input logic ready, input logic sel, input logic [31:0] tgt,
                        input bit do_chk);
        logic [31:0] dest;
        @(negedge clk);
        rst_n = rst; imem_ack = ack; imem_rdata = rdata;
        instr_ready = ready; pcsrc = sel; pc_target = tgt;
        #1;
        if (do_chk) begin
            chk("req", {31'd0, imem_req}, {31'd0, m_fetching});
            chk("addr", imem_addr, m_pc);
            chk("valid", {31'd0, instr_valid}, {31'd0, m_have});
            chk("instr", instr, m_instr);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("fault", {31'd0, fault}, {31'd0, m_fault});
        end
        if (!rst) begin
            m_pc = RstPc; m_instr = Nop; m_booting = 1; m_fetching = 0; m_have = 0; m_fault = 0;
        end else if (m_booting) begin
            m_booting = 0; m_fetching = 1;
        end else if (m_fetching) begin
            if (ack) begin m_instr = rdata; m_fetching = 0; m_have = 1; end
        end else if (m_have && ready) begin
            m_have = 0;
            if (sel && MisalignCheck && tgt % 4 != 0) begin
                m_pc = tgt; m_fault = 1;
            end else begin
                dest = sel ? tgt - (tgt % 4) : m_pc + 32'd4;
                m_pc = dest; m_fetching = 1;
            end
        end
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        sel;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] t;
        // Directed table: outputs expected in the same cycle the inputs are applied.
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h100,       1'b0, Nop};
        tbl[1]  = '{1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, Nop};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h300,       1'b0, 32'h100,       1'b1, 32'hAAAA_0001};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h300,       1'b0, 32'h100,       1'b1, 32'hAAAA_0001};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h400,       1'b1, 32'h104,       1'b0, 32'hAAAA_0001};
        tbl[5]  = '{1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       1'b0, 32'hAAAA_0001};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       1'b0, 32'h104,       1'b1, 32'h0000_0033};
        tbl[7]  = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0000_0033};
        tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h200,       1'b1, 32'h0000_0011};
        tbl[9]  = '{1'b1, 32'h0000_0022, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0011};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0022};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0022};

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h8, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst_n = 1; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            instr_ready = tbl[i].ready; pcsrc = tbl[i].sel; pc_target = tbl[i].tgt;
            #1;
            chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
        end

        // Delayed ack with toggling read data: only the ack-cycle word is captured.
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, $urandom, 0, 0, 0, 1);
        step(1, 1, 32'h1234_5678, 0, 0, 0, 1);
        // Hold for five cycles with a redirect presented but not consumed.
        for (int i = 0; i < 5; i++) step(1, 1, $urandom, 0, 1, 32'h500, 1);
        chk("hold_instr", instr, 32'h1234_5678);
        step(1, 0, 0, 1, 0, 32'h500, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("seq_addr", imem_addr, RstPc + 32'd4);
        step(1, 1, 32'h0000_0063, 0, 0, 0, 1);

        // Misaligned redirect.
        step(1, 0, 0, 1, 1, 32'h202, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 32'h5555_5555, 1, 0, 0, 1);
        chk("mis_fault", {31'd0, fault}, {31'd0, MisalignCheck});
        chk("mis_pc", pc, MisalignCheck ? 32'h202 : 32'h204);

        // Reset mid-request, then a late ack during the boot cycle.
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 32'hBAD0_BAD0, 0, 0, 0, 1);
        chk("late_ack_instr", instr, Nop);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("refetch_addr", imem_addr, RstPc);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            step(($urandom_range(0, 60) != 0), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1), t, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
